// File: rtl/mig_tg_pkg.sv
// Shared definitions for the MIG traffic generator / frame arbiter family.
package mig_tg_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Free-slot threshold behind the read FIFO's almost-full flag.
  localparam int AF_SLOTS = 12;

  typedef enum logic [1:0] {
    RST,
    WAIT_INIT,
    RD,
    WR
  } tg_state_t;

endpackage

// File: rtl/evt_counter.sv
// Wrapping event counter: counts 0 .. MAX_COUNT-1, clear has priority over increment.
module evt_counter #(
  parameter int MAX_COUNT = 8,
  parameter int W         = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, wrapping back to zero after the last value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == W'(MAX_COUNT - 1)) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mig_frame_arbiter.sv
// Arbitrates MIG UI commands between a camera write stream and an HDMI read
// stream, ping-ponging two frame buffers so the reader never scans a frame
// that is still being written.
module mig_frame_arbiter
  import mig_tg_pkg::*;
#(
  parameter int FRAME_WIDTH   = 1280,
  parameter int FRAME_HEIGHT  = 720,
  parameter int BPP           = 16,
  parameter int DOUBLE_BUF    = 1,
  parameter int MAX_CMD_QUEUE = 8,
  parameter int WR_BURST_MAX  = 64
) (
  input  logic         clk_in,
  input  logic         rst_in_n,
  input  logic         init_calib_complete,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_end,
  output logic         app_wdf_wren,
  output logic [15:0]  app_wdf_mask,
  output logic         app_sr_req,
  output logic         app_ref_req,
  output logic         app_zq_req,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  input  logic [127:0] write_axis_data,
  input  logic         write_axis_valid,
  input  logic         write_axis_tlast,
  output logic         write_axis_ready,
  output logic [127:0] read_axis_data,
  output logic         read_axis_valid,
  output logic         read_axis_tlast,
  input  logic         read_axis_af,
  input  logic         read_axis_ready,
  output logic         rd_buf_idx,
  output logic         wr_buf_idx,
  output logic         frame_drop
);

  localparam int WORDS = FRAME_WIDTH * FRAME_HEIGHT * BPP / 128;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OW    = $clog2(MAX_CMD_QUEUE + 1);
  localparam int RW    = (WR_BURST_MAX > 1) ? $clog2(WR_BURST_MAX) : 1;

  if ((FRAME_WIDTH * FRAME_HEIGHT * BPP) % 128 != 0) begin : g_bad_geometry
    $error("frame size in bits must be a multiple of 128");
  end
  if (2 * WORDS * 8 > 2 ** 27) begin : g_bad_addr_width
    $error("two frame buffers do not fit in the 27-bit MIG address");
  end

  // The MIG cannot be stalled, so this is informational only.
  logic unused_read_ready;
  assign unused_read_ready = read_axis_ready;

  logic [1:0]     rst_sync;
  logic           rst_n;
  tg_state_t      state;
  logic [CW-1:0]  wr_off, rd_off, resp_off;
  logic [OW-1:0]  out_cnt;
  logic [RW-1:0]  wr_run;
  logic           fresh;
  logic           link_ok, wr_hs, wr_last, rd_req_valid, rd_fire, swap;
  logic [26:0]    rd_base, wr_base, word_addr;

  // Assert reset immediately, release it cleanly on a ui_clk edge.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign link_ok          = app_rdy && app_wdf_rdy && (state == WR);
  assign write_axis_ready = link_ok;
  assign wr_hs            = write_axis_valid && link_ok;
  assign wr_last          = wr_hs && write_axis_tlast;
  assign rd_req_valid     = (state == RD) && (out_cnt < OW'(MAX_CMD_QUEUE)) && !read_axis_af;
  assign rd_fire          = rd_req_valid && app_rdy;
  assign swap             = (DOUBLE_BUF != 0) && rd_fire && (rd_off == CW'(WORDS - 1))
                            && (fresh || wr_last);

  assign app_en       = wr_hs || rd_fire;
  assign app_cmd      = (state == WR) ? CMD_WRITE : CMD_READ;
  assign app_wdf_wren = wr_hs;
  assign app_wdf_end  = wr_hs;
  assign app_wdf_data = write_axis_data;
  assign app_wdf_mask = '0;
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;

  assign read_axis_valid = app_rd_data_valid && ((state == RD) || (state == WR));
  assign read_axis_data  = app_rd_data;
  assign read_axis_tlast = read_axis_valid && (resp_off == CW'(WORDS - 1));

  assign rd_base = rd_buf_idx ? 27'(WORDS) : '0;
  assign wr_base = wr_buf_idx ? 27'(WORDS) : '0;

  // Select the word address of whichever side owns the command bus.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_addr = '0;
    case (state)
      RD:      word_addr = rd_base + 27'(rd_off);
      WR:      word_addr = wr_base + 27'(wr_off);
      default: word_addr = '0;
    endcase
  end
  assign app_addr = word_addr << 3;

  // Command arbitration FSM with the per-visit write run length.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST;
      wr_run <= '0;
    end else begin
      case (state)
        RST:       state <= WAIT_INIT;
        WAIT_INIT: if (init_calib_complete) state <= RD;
        RD: begin
          if ((out_cnt == OW'(MAX_CMD_QUEUE)) || read_axis_af
              || (write_axis_valid && !rd_req_valid)) begin
            state  <= WR;
            wr_run <= '0;
          end
        end
        WR: begin
          if (wr_hs) wr_run <= wr_run + 1'b1;
          if (!write_axis_valid || (wr_hs && (wr_run == RW'(WR_BURST_MAX - 1))))
            state <= RD;
        end
        default: state <= RST;
      endcase
    end
  end

  // Track reads issued to the MIG but not yet returned.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({rd_fire, app_rd_data_valid})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Ping-pong buffer ownership, completed-frame flag and drop pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_buf_idx <= 1'b0;
      wr_buf_idx <= 1'(DOUBLE_BUF != 0);
      fresh      <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= (DOUBLE_BUF != 0) && wr_last && fresh;
      if (swap) begin
        rd_buf_idx <= ~rd_buf_idx;
        wr_buf_idx <= ~wr_buf_idx;
        fresh      <= 1'b0;
      end else if (wr_last) begin
        fresh <= 1'b1;
      end
    end
  end

  // Write offset realigns on tlast so short frames restart at offset zero.
  evt_counter #(.MAX_COUNT(WORDS)) u_wr_off (
    .clk(clk_in), .rst_n(rst_n), .clr(wr_last), .inc(wr_hs), .count(wr_off)
  );

  evt_counter #(.MAX_COUNT(WORDS)) u_rd_off (
    .clk(clk_in), .rst_n(rst_n), .clr(1'b0), .inc(rd_fire), .count(rd_off)
  );

  evt_counter #(.MAX_COUNT(WORDS)) u_resp_off (
    .clk(clk_in), .rst_n(rst_n), .clr(1'b0), .inc(read_axis_valid), .count(resp_off)
  );

endmodule

// File: tb/tb_mig_frame_arbiter.sv
// Directed scoreboard bench for mig_frame_arbiter with an 8-word frame.
module tb_mig_frame_arbiter;
  import mig_tg_pkg::*;

  logic         clk_in = 1'b0;
  logic         rst_in_n, init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_wdf_end, app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_sr_req, app_ref_req, app_zq_req;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [127:0] app_rd_data, write_axis_data, read_axis_data;
  logic         write_axis_valid, write_axis_tlast, write_axis_ready;
  logic         read_axis_valid, read_axis_tlast, read_axis_af, read_axis_ready;
  logic         rd_buf_idx, wr_buf_idx, frame_drop;

  always #5 clk_in = ~clk_in;

  mig_frame_arbiter #(
    .FRAME_WIDTH(16), .FRAME_HEIGHT(4), .BPP(16), .DOUBLE_BUF(1),
    .MAX_CMD_QUEUE(8), .WR_BURST_MAX(4)
  ) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_wren(app_wdf_wren),
    .app_wdf_mask(app_wdf_mask), .app_sr_req(app_sr_req), .app_ref_req(app_ref_req),
    .app_zq_req(app_zq_req), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .write_axis_data(write_axis_data), .write_axis_valid(write_axis_valid),
    .write_axis_tlast(write_axis_tlast), .write_axis_ready(write_axis_ready),
    .read_axis_data(read_axis_data), .read_axis_valid(read_axis_valid),
    .read_axis_tlast(read_axis_tlast), .read_axis_af(read_axis_af),
    .read_axis_ready(read_axis_ready), .rd_buf_idx(rd_buf_idx),
    .wr_buf_idx(wr_buf_idx), .frame_drop(frame_drop)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t        beat_q[$];      // camera beats still to be accepted
  logic [127:0] rsp_q[$];       // MIG read responses still to be returned
  beat_t        exp_resp_q[$];  // expected HDMI output beats
  logic [26:0]  exp_rd_q[$];    // expected read command addresses
  logic [26:0]  exp_wr_q[$];    // expected write command addresses

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int run_len  = 0;
  int max_run  = 0;
  int drop_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    write_axis_valid  = (beat_q.size() != 0);
    write_axis_data   = write_axis_valid ? beat_q[0].data : '0;
    write_axis_tlast  = write_axis_valid ? beat_q[0].last : 1'b0;
    app_rd_data_valid = (rsp_q.size() != 0);
    app_rd_data       = app_rd_data_valid ? rsp_q[0] : '0;
  endtask

  task automatic monitor(input logic hs);
    logic [26:0] ea;
    beat_t       eb;
    if (app_en && app_cmd == CMD_WRITE) begin
      chk("wr_is_handshake", hs, 1'b1);
      chk("wdf_wren", app_wdf_wren, 1'b1);
      chk("wdf_end", app_wdf_end, 1'b1);
      chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
      if (exp_wr_q.size() != 0) begin
        ea = exp_wr_q.pop_front();
        chk("wr_addr", app_addr, ea);
      end
      if (hs) chk("wr_data", app_wdf_data, beat_q[0].data);
    end else if (app_en) begin
      chk("rd_cmd", app_cmd, CMD_READ);
      chk("rd_expected", exp_rd_q.size() != 0, 1'b1);
      if (exp_rd_q.size() != 0) begin
        ea = exp_rd_q.pop_front();
        chk("rd_addr", app_addr, ea);
      end
      rd_count++;
    end else begin
      chk("hs_without_en", hs, 1'b0);
      chk("wren_idle", app_wdf_wren, 1'b0);
    end
    run_len = hs ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    if (frame_drop) drop_cnt++;
    if (read_axis_valid) begin
      chk("rsp_expected", exp_resp_q.size() != 0, 1'b1);
      if (exp_resp_q.size() != 0) begin
        eb = exp_resp_q.pop_front();
        chk("rsp_data", read_axis_data, eb.data);
        chk("rsp_tlast", read_axis_tlast, eb.last);
      end
    end else begin
      chk("tlast_idle", read_axis_tlast, 1'b0);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, retire consumed items.
  task automatic cycle();
    logic hs;
    logic rv;
    drive();
    @(negedge clk_in);
    hs = write_axis_valid && write_axis_ready;
    rv = app_rd_data_valid;
    monitor(hs);
    @(posedge clk_in);
    #1;
    if (hs) void'(beat_q.pop_front());
    if (rv) void'(rsp_q.pop_front());
  endtask

  // Run until all queues drain (bounded), then a few idle cycles.
  task automatic settle(input string tag, input int budget, input int extra);
    int n;
    n = 0;
    while ((beat_q.size() + rsp_q.size() + exp_rd_q.size() + exp_wr_q.size()
            + exp_resp_q.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    repeat (extra) cycle();
    chk({tag, "_drained"}, beat_q.size() + rsp_q.size() + exp_rd_q.size()
        + exp_wr_q.size() + exp_resp_q.size(), 0);
  endtask

  task automatic push_reads(input int buf_idx);
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(27'((buf_idx * 8 + i) << 3));
  endtask

  task automatic push_frame(input int buf_idx, input int seed, input int n, input logic last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {32'(seed), 32'(i), 32'hCAFE_0000 + 32'(i), 32'(seed ^ i)};
      b.last = last && (i == n - 1);
      beat_q.push_back(b);
      exp_wr_q.push_back(27'((buf_idx * 8 + i) << 3));
    end
  endtask

  task automatic return_responses(input int seed);
    beat_t b;
    app_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b.data = {4{16'(seed), 16'(i)}};
      b.last = (i == 7);
      rsp_q.push_back(b.data);
      exp_resp_q.push_back(b);
    end
    settle("responses", 30, 2);
    app_rdy = 1'b1;
  endtask

  initial begin
    rst_in_n = 1'b0; init_calib_complete = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    read_axis_af = 1'b0; read_axis_ready = 1'b1;
    drive();

    // Reset state.
    repeat (3) cycle();
    chk("rst_rd_buf_idx", rd_buf_idx, 1'b0);
    chk("rst_wr_buf_idx", wr_buf_idx, 1'b1);
    chk("rst_frame_drop", frame_drop, 1'b0);
    chk("rst_app_addr", app_addr, 27'd0);
    chk("rst_tieoffs", {app_wdf_mask, app_sr_req, app_ref_req, app_zq_req}, 19'd0);
    rst_in_n = 1'b1;

    // Calibration pending: nothing may be issued.
    for (int i = 0; i < 100; i++) begin
      cycle();
      chk("wait_init_app_en", app_en, 1'b0);
      chk("wait_init_wready", write_axis_ready, 1'b0);
    end

    // Reads of buffer 0 until the command queue is full.
    init_calib_complete = 1'b1;
    push_reads(0);
    settle("reads_b0", 60, 20);
    chk("reads_before_full", rd_count, 8);
    return_responses(1);

    // One frame into buffer 1 with reads held off; burst length limited to 4.
    read_axis_af = 1'b1;
    max_run = 0;
    push_frame(1, 16'hA1, 8, 1'b1);
    settle("frame_b1", 60, 6);
    chk("burst_limit", max_run, 4);
    chk("no_drop_yet", drop_cnt, 0);
    chk("pre_swap_rd_idx", rd_buf_idx, 1'b0);

    // Reader wraps buffer 0 with a fresh frame pending -> swap.
    read_axis_af = 1'b0;
    push_reads(0);
    settle("reads_swap", 60, 10);
    chk("swap_rd_idx", rd_buf_idx, 1'b1);
    chk("swap_wr_idx", wr_buf_idx, 1'b0);
    return_responses(2);
    push_reads(1);
    settle("reads_b1", 60, 10);
    return_responses(3);

    // Two frames into buffer 0 before the reader wraps -> one drop.
    read_axis_af = 1'b1;
    push_frame(0, 16'hB2, 8, 1'b1);
    push_frame(0, 16'hB3, 8, 1'b1);
    settle("two_frames", 100, 6);
    chk("drop_once", drop_cnt, 1);
    chk("no_swap_rd_idx", rd_buf_idx, 1'b1);

    // Reset in the middle of a write burst.
    push_frame(0, 16'hC4, 8, 1'b0);
    for (int i = 0; i < 40 && beat_q.size() > 6; i++) cycle();
    chk("burst_started", beat_q.size(), 6);
    #2 rst_in_n = 1'b0;
    #1;
    chk("async_app_en", app_en, 1'b0);
    chk("async_wready", write_axis_ready, 1'b0);
    chk("async_wren", app_wdf_wren, 1'b0);
    chk("async_addr", app_addr, 27'd0);
    chk("async_wr_idx", wr_buf_idx, 1'b1);
    chk("async_rd_idx", rd_buf_idx, 1'b0);
    beat_q.delete();
    exp_wr_q.delete();
    repeat (3) cycle();
    rst_in_n = 1'b1;
    push_frame(1, 16'hD5, 1, 1'b0);
    settle("post_reset_write", 40, 4);
    chk("final_drop_count", drop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
